// File: rtl/dcache_mem_ctrl.sv
// dcache miss handler: writes back a dirty victim line, then refills the missing line as a 64-bit beat burst.
// Define DCACHE_MEM_CTRL_PERF_EN to add the saturating miss and write-back counters (o_miss_cnt, o_wb_cnt).
module dcache_mem_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SET_WIDTH  = 512
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_miss,
  input  logic                  i_dirty,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0] i_addr_wb,
  input  logic [SET_WIDTH-1:0]  i_wb_block,
  output logic                  o_block_we,
  output logic [SET_WIDTH-1:0]  o_data_block,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_we,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic                  o_mem_wvalid,
  input  logic                  i_mem_wready,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef DCACHE_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]           o_miss_cnt,
  output logic [31:0]           o_wb_cnt
`endif
);

  localparam int BEATS = SET_WIDTH / DATA_WIDTH;
  localparam int OFF   = $clog2(SET_WIDTH / 8);
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL} state_t;

  state_t                state, next_state;
  logic [CW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] miss_addr, wb_addr;
  logic [SET_WIDTH-1:0]  wb_line, buffer;
  logic                  skip_miss;
  logic                  miss_accept;
  logic                  addr_unused;

  // Only line-aligned addresses are ever issued, so the offset bits are dropped.
  assign addr_unused = ^{i_addr[OFF-1:0], i_addr_wb[OFF-1:0]};

  // The dcache still shows the old miss for one cycle after the refill lands.
  assign miss_accept = (state == IDLE) && i_miss && !skip_miss;

  always_ff @(posedge i_clk) begin
    if (i_arst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss_accept) next_state = i_dirty ? WB_REQ : RD_REQ;
      WB_REQ:  if (i_mem_req_ready) next_state = WB_DATA;
      WB_DATA: if (i_mem_wready && beat == LAST) next_state = RD_REQ;
      RD_REQ:  if (i_mem_req_ready) next_state = RD_DATA;
      RD_DATA: if (i_mem_rvalid && beat == LAST) next_state = FILL;
      FILL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      beat      <= '0;
      miss_addr <= '0;
      wb_addr   <= '0;
      wb_line   <= '0;
      buffer    <= '0;
      skip_miss <= 1'b0;
    end else begin
      skip_miss <= (state == FILL);
      if (miss_accept) begin
        miss_addr <= {i_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        wb_addr   <= {i_addr_wb[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        wb_line   <= i_wb_block;
      end
      if ((state == WB_DATA && i_mem_wready) || (state == RD_DATA && i_mem_rvalid))
        beat <= (beat == LAST) ? '0 : beat + 1'b1;
      if (state == RD_DATA && i_mem_rvalid)
        buffer[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
    end
  end

  always_comb begin
    o_block_we      = 1'b0;
    o_done          = 1'b0;
    o_data_block    = '0;
    o_busy          = (state != IDLE);
    o_mem_req_valid = 1'b0;
    o_mem_req_we    = 1'b0;
    o_mem_req_addr  = '0;
    o_mem_wvalid    = 1'b0;
    o_mem_wdata     = '0;
    case (state)
      WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_we    = 1'b1;
        o_mem_req_addr  = wb_addr;
      end
      WB_DATA: begin
        o_mem_wvalid = 1'b1;
        o_mem_wdata  = wb_line[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
      end
      RD_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = miss_addr;
      end
      FILL: begin
        o_block_we   = 1'b1;
        o_done       = 1'b1;
        o_data_block = buffer;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_MEM_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      o_miss_cnt <= '0;
      o_wb_cnt   <= '0;
    end else begin
      if (miss_accept && o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 32'd1;
      if (state == WB_REQ && i_mem_req_ready && o_wb_cnt != '1) o_wb_cnt <= o_wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl: a table of miss scenarios driven against a small memory responder.
module tb_dcache_mem_ctrl;

  logic         i_clk = 1'b0;
  logic         i_arst;
  logic         i_miss;
  logic         i_dirty;
  logic [63:0]  i_addr;
  logic [63:0]  i_addr_wb;
  logic [511:0] i_wb_block;
  logic         o_block_we;
  logic [511:0] o_data_block;
  logic         o_busy;
  logic         o_done;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic         o_mem_req_we;
  logic [63:0]  o_mem_req_addr;
  logic         o_mem_wvalid;
  logic         i_mem_wready;
  logic [63:0]  o_mem_wdata;
  logic         i_mem_rvalid;
  logic [63:0]  i_mem_rdata;
`ifdef DCACHE_MEM_CTRL_PERF_EN
  logic [31:0]  o_miss_cnt;
  logic [31:0]  o_wb_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dcache_mem_ctrl dut (
    .i_clk           (i_clk),
    .i_arst          (i_arst),
    .i_miss          (i_miss),
    .i_dirty         (i_dirty),
    .i_addr          (i_addr),
    .i_addr_wb       (i_addr_wb),
    .i_wb_block      (i_wb_block),
    .o_block_we      (o_block_we),
    .o_data_block    (o_data_block),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_we    (o_mem_req_we),
    .o_mem_req_addr  (o_mem_req_addr),
    .o_mem_wvalid    (o_mem_wvalid),
    .i_mem_wready    (i_mem_wready),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rvalid    (i_mem_rvalid),
    .i_mem_rdata     (i_mem_rdata)
`ifdef DCACHE_MEM_CTRL_PERF_EN
    ,
    .o_miss_cnt      (o_miss_cnt),
    .o_wb_cnt        (o_wb_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // One miss scenario: memory behaviour knobs plus hand-computed expected addresses and latency.
  typedef struct {
    bit          dirty;
    logic [63:0] addr;
    logic [63:0] addr_wb;
    logic [63:0] rd_addr_exp;
    logic [63:0] wb_addr_exp;
    logic [63:0] wb_base;
    logic [63:0] rd_base;
    int          stall;
    bit          wtoggle;
    bit          rgap;
    int          rst_at;
    int          latency;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_block_we"}, o_block_we, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_req_valid"}, o_mem_req_valid, 0);
    checkOutput({tag, "_req_we"}, o_mem_req_we, 0);
    checkOutput({tag, "_req_addr"}, o_mem_req_addr, 0);
    checkOutput({tag, "_wvalid"}, o_mem_wvalid, 0);
    checkOutput({tag, "_wdata"}, o_mem_wdata, 0);
    checkOutput({tag, "_data_block"}, o_data_block, 0);
  endtask

  // Runs one miss from the IDLE cycle in which i_miss is first sampled (cycle 1) to completion.
  task automatic applyStimulus(input vec_t v);
    int           cycle = 1;
    int           req_idx = 0;
    int           stall = 0;
    int           wcount = 0;
    int           rcount = 0;
    int           gap = 0;
    int           nreq;
    bit           rd_acc = 0;
    bit           done_seen = 0;
    bit           exp_we;
    logic [511:0] exp_line;
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = v.rd_base + 64'(k);
    nreq = v.dirty ? 2 : 1;

    i_miss    = 1'b1;
    i_dirty   = v.dirty;
    i_addr    = v.addr;
    i_addr_wb = v.addr_wb;
    for (int k = 0; k < 8; k++) i_wb_block[k*64 +: 64] = v.wb_base + 64'(k);
    i_mem_req_ready = 1'b0;
    i_mem_wready    = 1'b0;
    i_mem_rvalid    = 1'b0;

    while (!done_seen && cycle < 200) begin
      @(negedge i_clk);
      cycle++;
      if (cycle == 2) begin
        i_wb_block = '1;
        i_addr_wb  = '1;
        i_dirty    = ~v.dirty;
      end
      checkOutput("busy", o_busy, 1);

      if (v.rst_at >= 0 && rd_acc && rcount == v.rst_at) begin
        i_arst = 1'b1;
        i_miss = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_wready = 1'b0;
        @(negedge i_clk);
        i_arst = 1'b0;
        checkIdle("after_reset");
        repeat (10) begin
          @(negedge i_clk);
          checkOutput("no_fill_after_reset", o_block_we, 0);
        end
        return;
      end

      i_mem_rvalid = 1'b0;
      if (rd_acc && rcount < 8) begin
        gap++;
        if (!v.rgap || gap % 3 == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = v.rd_base + 64'(rcount);
          rcount++;
        end
      end

      i_mem_req_ready = 1'b0;
      if (o_mem_req_valid) begin
        if (req_idx >= nreq) checkOutput("req_count", req_idx + 1, nreq);
        else begin
          exp_we = v.dirty && req_idx == 0;
          checkOutput("req_we", o_mem_req_we, exp_we);
          checkOutput("req_addr", o_mem_req_addr, exp_we ? v.wb_addr_exp : v.rd_addr_exp);
          if (stall < v.stall) stall++;
          else begin
            i_mem_req_ready = 1'b1;
            stall = 0;
            req_idx++;
            if (!exp_we) rd_acc = 1'b1;
          end
        end
      end

      i_mem_wready = 1'b0;
      if (o_mem_wvalid) begin
        checkOutput("wdata", o_mem_wdata, v.wb_base + 64'(wcount));
        if (!v.wtoggle || cycle[0]) begin
          i_mem_wready = 1'b1;
          wcount++;
        end
      end

      if (o_block_we) begin
        done_seen = 1'b1;
        checkOutput("done", o_done, 1);
        checkOutput("beats_before_fill", rcount, 8);
        checkOutput("line", o_data_block, exp_line);
        if (v.latency != 0) checkOutput("latency", cycle, v.latency);
      end else begin
        checkOutput("done_without_we", o_done, 0);
      end
    end

    checkOutput("done_seen", done_seen, 1);
    checkOutput("write_beats", wcount, v.dirty ? 8 : 0);
    checkOutput("req_total", req_idx, nreq);
    i_mem_rvalid = 1'b0;
    // i_miss stays high one more cycle, as a dcache not yet updated would show it.
    @(negedge i_clk);
    checkOutput("idle_after_fill", o_busy, 0);
    checkOutput("single_fill", o_block_we, 0);
    @(negedge i_clk);
    checkOutput("stale_miss_ignored", o_busy, 0);
    i_miss = 1'b0;
    @(negedge i_clk);
    checkOutput("quiet_after_miss", o_busy, 0);
  endtask

  initial begin
    // dirty, addr, addr_wb, rd_addr_exp, wb_addr_exp, wb_base, rd_base, stall, wtoggle, rgap, rst_at, latency
    vecs[0] = '{1'b0, 64'h1234, 64'h0, 64'h1200, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0, -1, 11};
    vecs[1] = '{1'b1, 64'h4_0050, 64'h8000, 64'h4_0040, 64'h8000, 64'hA0, 64'h100, 0, 1'b0, 1'b0, -1, 20};
    vecs[2] = '{1'b1, 64'hDEAD_BEEF, 64'h1_007F, 64'hDEAD_BEC0, 64'h1_0040, 64'h5500, 64'h7700, 3, 1'b1, 1'b0, -1, 0};
    vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFC5, 64'h0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 64'h0, 64'hC0DE_0000, 0, 1'b0, 1'b1, -1, 0};
    vecs[4] = '{1'b0, 64'h2000, 64'h0, 64'h2000, 64'h0, 64'h0, 64'h99, 0, 1'b0, 1'b0, 4, 0};
    vecs[5] = '{1'b0, 64'h1234, 64'h0, 64'h1200, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0, -1, 11};
    vecs[6] = '{1'b1, 64'h3F, 64'hFFC0, 64'h0, 64'hFFC0, 64'h1000_0000_0000_0000, 64'h4242, 0, 1'b0, 1'b0, -1, 20};
    vecs[7] = '{1'b0, 64'h40, 64'h0, 64'h40, 64'h0, 64'h0, 64'h5A5A_0000, 0, 1'b0, 1'b0, -1, 11};

    i_arst = 1'b1;
    i_miss = 1'b0;
    i_dirty = 1'b0;
    i_addr = '0;
    i_addr_wb = '0;
    i_wb_block = '0;
    i_mem_req_ready = 1'b0;
    i_mem_wready = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    repeat (2) @(negedge i_clk);
    checkIdle("reset");
    i_arst = 1'b0;
    @(negedge i_clk);
    checkIdle("post_reset");

    for (int i = 0; i < 8; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(vecs[i]);
    end

`ifdef DCACHE_MEM_CTRL_PERF_EN
    checkOutput("miss_cnt", o_miss_cnt, 3);
    checkOutput("wb_cnt", o_wb_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
